// File: rtl/sin_tbl_sqrt.sv
// FMCW sonar arithmetic support: registered quarter-wave sine lookup (with a
// quadrature twin) and a 12-stage pipelined integer square root.

module sin_tbl_sqrt (
  input  logic        CK_i,
  input  logic        XARST_i,
  input  logic [11:0] DAT_i,
  input  logic [22:0] DATs_i,
  output logic [11:0] SIN_o,
  output logic [11:0] COS_o,
  output logic [11:0] QQs_o
);
  logic [11:0] dat_q_s;

  // Quadrature phase is DAT_i - 0x400, which only touches the quadrant bits.
  assign dat_q_s = {DAT_i[11:10] - 2'b01, DAT_i[9:0]};

  sin_tbl_s11_s11 u_sin (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .DAT_i   (DAT_i),
    .SIN_o   (SIN_o)
  );

  sin_tbl_s11_s11 u_cos (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .DAT_i   (dat_q_s),
    .SIN_o   (COS_o)
  );

  SQRT u_sqrt (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .DATs_i  (DATs_i),
    .QQs_o   (QQs_o)
  );
endmodule

module sin_tbl_s11_s11 (
  input  logic        CK_i,
  input  logic        XARST_i,
  input  logic [11:0] DAT_i,
  output logic [11:0] SIN_o
);
  function automatic int quarter_sine(input int idx);
    real amp_v;
    amp_v = 2047.0 * $sin(3.14159265358979323846 * real'(idx) / 2048.0);
    return $rtoi(amp_v + 0.5);
  endfunction

  logic [10:0] rom_s [0:1024];
  logic [10:0] idx_s;
  logic [10:0] mag_s;
  logic [11:0] sin_s;
  logic [11:0] sin_r;

  // Entry 1024 holds the explicit peak so mirrored quadrants reach 2047.
  for (genvar g = 0; g <= 1024; g++) begin : g_rom
    localparam logic [10:0] ROM_VAL = 11'(quarter_sine(g));
    assign rom_s[g] = ROM_VAL;
  end

  // Mirror the address in odd quadrants, negate in the lower half-wave.
  always_comb begin
    idx_s = {1'b0, DAT_i[9:0]};
    if (DAT_i[10]) begin
      idx_s = 11'd1024 - {1'b0, DAT_i[9:0]};
    end else begin
      idx_s = {1'b0, DAT_i[9:0]};
    end
    mag_s = rom_s[idx_s];
    if (DAT_i[11]) begin
      sin_s = 12'd0 - {1'b0, mag_s};
    end else begin
      sin_s = {1'b0, mag_s};
    end
  end

  // Output register; reset forces a zero amplitude.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      sin_r <= 12'd0;
    end else begin
      sin_r <= sin_s;
    end
  end

  assign SIN_o = sin_r;
endmodule

module SQRT (
  input  logic        CK_i,
  input  logic        XARST_i,
  input  logic [22:0] DATs_i,
  output logic [11:0] QQs_o
);
  localparam int STAGES = 12;

  typedef struct packed {
    logic [23:0] rad;
    logic [13:0] rem;
    logic [11:0] root;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  // One digit-by-digit step: bring down two radicand bits, try root*4+1.
  function automatic stage_t sqrt_step(input stage_t cur);
    stage_t      nxt;
    logic [15:0] rem_sh;
    logic [15:0] trial;
    rem_sh  = {cur.rem, cur.rad[23:22]};
    trial   = {2'b00, cur.root, 2'b01};
    nxt.rad = {cur.rad[21:0], 2'b00};
    if (rem_sh >= trial) begin
      nxt.rem  = 14'(rem_sh - trial);
      nxt.root = {cur.root[10:0], 1'b1};
    end else begin
      nxt.rem  = rem_sh[13:0];
      nxt.root = {cur.root[10:0], 1'b0};
    end
    return nxt;
  endfunction

  stage_t seed_s;
  stage_t nxt_s [0:STAGES-1];
  stage_t stg_r [0:STAGES-1];

  // Next-state of every pipeline stage from its predecessor.
  always_comb begin
    seed_s   = {1'b0, DATs_i, 14'd0, 12'd0};
    nxt_s[0] = sqrt_step(seed_s);
    for (int k = 1; k < STAGES; k++) begin
      nxt_s[k] = sqrt_step(stg_r[k-1]);
    end
  end

  // Pipeline registers; reset flushes every in-flight value.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_r[k] <= {STAGE_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stg_r[k] <= nxt_s[k];
      end
    end
  end

  assign QQs_o = stg_r[STAGES-1].root;
endmodule

// File: tb/tb_sin_tbl_sqrt.sv
// Self-checking bench for sin_tbl_sqrt: directed cardinal points, full sine
// sweep with symmetry/quadrature relations, random sqrt stream and resets.

module tb_sin_tbl_sqrt;
  logic        CK_i = 1'b0;
  logic        XARST_i;
  logic [11:0] DAT_i;
  logic [22:0] DATs_i;
  logic [11:0] SIN_o;
  logic [11:0] COS_o;
  logic [11:0] QQs_o;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [11:0] sin_exp;
  logic [11:0] cos_exp;
  logic [11:0] prev_dat;
  logic [11:0] exp_q [$];
  logic [11:0] sin_obs [0:4095];
  logic [11:0] cos_obs [0:4095];

  logic [11:0] dir_d   [8] = '{12'h000, 12'h400, 12'hC00, 12'h800,
                               12'h200, 12'hE00, 12'h7FF, 12'h001};
  logic [11:0] dir_sin [8] = '{12'h000, 12'h7FF, 12'h801, 12'h000,
                               12'd1447, 12'hA59, 12'h003, 12'h003};
  logic [11:0] dir_cos [8] = '{12'h801, 12'h000, 12'h000, 12'h7FF,
                               12'hA59, 12'hA59, 12'h7FF, 12'h801};
  logic [22:0] sq_d    [8] = '{23'd0, 23'd1, 23'd3, 23'd4,
                               23'd4194304, 23'd8386815, 23'd8386816, 23'd8388607};
  logic [11:0] sq_q    [8] = '{12'd0, 12'd1, 12'd1, 12'd2,
                               12'd2048, 12'd2895, 12'd2896, 12'd2896};

  always #5 CK_i = ~CK_i;

  sin_tbl_sqrt dut (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .DAT_i   (DAT_i),
    .DATs_i  (DATs_i),
    .SIN_o   (SIN_o),
    .COS_o   (COS_o),
    .QQs_o   (QQs_o)
  );

  function automatic logic [11:0] sin_ref(input logic [11:0] code);
    real v;
    int  r;
    v = 2047.0 * $sin(3.14159265358979323846 * real'($signed(code)) / 2048.0);
    if (v >= 0.0) r = $rtoi($floor(v + 0.5));
    else          r = -$rtoi($floor(-v + 0.5));
    if (r > 2047)  r = 2047;
    if (r < -2047) r = -2047;
    return 12'(r);
  endfunction

  function automatic logic [11:0] sqrt_ref(input logic [22:0] v);
    longint vl;
    longint r;
    vl = longint'(v);
    r  = longint'($sqrt(real'(vl)));
    while (r * r > vl) r--;
    while ((r + 1) * (r + 1) <= vl) r++;
    return 12'(r);
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  // Pipeline state after reset: sine reads 0, sqrt pipe holds twelve zeros.
  task automatic reset_model();
    sin_exp  = 12'd0;
    cos_exp  = 12'd0;
    prev_dat = 12'd0;
    exp_q.delete();
    repeat (12) exp_q.push_back(12'd0);
  endtask

  // Check outputs of the previous cycle, then drive a new input pair.
  task automatic step(input logic [11:0] d, input logic [22:0] r);
    check("sin", SIN_o, sin_exp);
    check("cos", COS_o, cos_exp);
    sin_obs[prev_dat] = SIN_o;
    cos_obs[prev_dat] = COS_o;
    if (exp_q.size() >= 12) check("sqrt", QQs_o, exp_q.pop_front());
    DAT_i    = d;
    DATs_i   = r;
    prev_dat = d;
    sin_exp  = sin_ref(d);
    cos_exp  = sin_ref(d - 12'h400);
    exp_q.push_back(sqrt_ref(r));
    @(negedge CK_i);
  endtask

  function automatic logic [22:0] rand_rad();
    if ($urandom_range(0, 7) == 0) return 23'h7FFFFF - 23'($urandom_range(0, 20000));
    return 23'($urandom);
  endfunction

  initial begin
    XARST_i = 1'b1;
    DAT_i   = 12'h123;
    DATs_i  = 23'd12345;
    #1 XARST_i = 1'b0;
    #2;
    check("rst_sin", SIN_o, 12'd0);
    check("rst_cos", COS_o, 12'd0);
    check("rst_sqrt", QQs_o, 12'd0);
    @(negedge CK_i);
    @(negedge CK_i);
    XARST_i = 1'b1;
    reset_model();

    for (int i = 0; i < 8; i++) begin
      step(dir_d[i], rand_rad());
      check("sin_card", SIN_o, dir_sin[i]);
      check("cos_card", COS_o, dir_cos[i]);
    end

    for (int i = 0; i < 8; i++) begin
      step(12'($urandom), sq_d[i]);
      exp_q[exp_q.size() - 1] = sq_q[i];
    end

    for (int x = 0; x < 4096; x++) step(12'(x), rand_rad());
    step(12'h000, rand_rad());
    for (int x = 0; x < 4096; x++) begin
      check("odd_sym", sin_obs[x], 12'd0 - sin_obs[12'(4096 - x)]);
      check("quad", cos_obs[x], sin_obs[12'(x - 1024)]);
    end

    for (int i = 0; i < 20000; i++) step(12'($urandom), rand_rad());

    #2 XARST_i = 1'b0;
    #1;
    check("midrst_sin", SIN_o, 12'd0);
    check("midrst_cos", COS_o, 12'd0);
    check("midrst_sqrt", QQs_o, 12'd0);
    @(negedge CK_i);
    @(negedge CK_i);
    XARST_i = 1'b1;
    reset_model();
    for (int i = 0; i < 300; i++) step(12'($urandom), rand_rad());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
